// File: rtl/vga_scanout_pkg.sv
// Shared types and timing helpers for the VGA raster engine.
// The tap_t layout depends on VGA_SCANOUT_TEMPORAL_DITHER_EN.
package vga_scanout_pkg;

  // Counter-side state that travels alongside the renderer latency.
  typedef struct packed {
    logic       active;
    logic       hs;
    logic       vs;
    logic [2:0] h3;
    logic [1:0] v2;
`ifdef VGA_SCANOUT_TEMPORAL_DITHER_EN
    logic       f0;
`endif
  } tap_t;

  function automatic int h_total(int disp, int front, int sync, int back);
    return disp + front + sync + back;
  endfunction

  function automatic int v_total(int disp, int front, int sync, int back);
    return disp + front + sync + back;
  endfunction

  // Sync window is [disp+front, disp+front+sync).
  function automatic int sync_beg(int disp, int front);
    return disp + front;
  endfunction

  function automatic int sync_end(int disp, int front, int sync);
    return disp + front + sync;
  endfunction

  // 5-bit ordered-dither threshold over an 8x4 tile.
  function automatic logic [4:0] bayer5(logic [2:0] i, logic [1:0] j);
    logic [2:0] x;
    x = {i[2], i[1] ^ j[1], i[0] ^ j[0]};
    return {x[0], i[0], x[1], i[1], x[2]};
  endfunction

endpackage

// File: rtl/vga_dither_ch.sv
// One colour channel: add the scaled threshold, truncate to OUT_BITS and saturate.
module vga_dither_ch #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 2
) (
  input  logic [IN_BITS-1:0]  c,
  input  logic [4:0]          b5,
  input  logic                active,
  output logic [OUT_BITS-1:0] q
);
  localparam int S  = IN_BITS - OUT_BITS;
  localparam int SW = (IN_BITS + 1 > 5) ? IN_BITS + 1 : 5;
  localparam logic [SW-1:0] MAXQ = SW'((1 << OUT_BITS) - 1);

  logic [4:0]    t;
  logic [SW-1:0] sum;
  logic [SW-1:0] qs;

  always_comb begin
    t   = b5 >> (5 - S);
    sum = SW'(c) + SW'(t);
    qs  = sum >> S;
    q   = '0;
    // Clamp instead of wrapping so bright input never rolls over to black.
    if (active) q = (qs > MAXQ) ? MAXQ[OUT_BITS-1:0] : qs[OUT_BITS-1:0];
  end
endmodule

// File: rtl/vga_scanout.sv
// VGA raster engine: counters, strobes, syncs and a latency-matched dither output stage.
// Define VGA_SCANOUT_TEMPORAL_DITHER_EN to flip the dither tile on odd frames.
module vga_scanout
  import vga_scanout_pkg::*;
#(
  parameter int H_DISPLAY  = 1220,
  parameter int H_FRONT    = 31,
  parameter int H_SYNC     = 183,
  parameter int H_BACK     = 92,
  parameter int V_DISPLAY  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int IN_BITS    = 6,
  parameter int OUT_BITS   = 2,
  parameter int PIPE       = 2,
  parameter int PREFETCH   = 16,
  parameter int FRAME_BITS = 11
) (
  input  logic                  clk48,
  input  logic                  rst_n,
  output logic [10:0]           h_count,
  output logic [9:0]            v_count,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  active,
  output logic                  line_stb,
  output logic                  frame_stb,
  output logic                  prefetch_stb,
  input  logic [IN_BITS-1:0]    r_in,
  input  logic [IN_BITS-1:0]    g_in,
  input  logic [IN_BITS-1:0]    b_in,
  output logic [OUT_BITS-1:0]   r_out,
  output logic [OUT_BITS-1:0]   g_out,
  output logic [OUT_BITS-1:0]   b_out,
  output logic                  hsync,
  output logic                  vsync
);
  localparam int S  = IN_BITS - OUT_BITS;
  localparam int HT = h_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int VT = v_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

  localparam logic [10:0] H_LAST = 11'(HT - 1);
  localparam logic [10:0] H_DISP = 11'(H_DISPLAY);
  localparam logic [10:0] H_PREF = 11'(H_DISPLAY - PREFETCH);
  localparam logic [10:0] HS_BEG = 11'(sync_beg(H_DISPLAY, H_FRONT));
  localparam logic [10:0] HS_END = 11'(sync_end(H_DISPLAY, H_FRONT, H_SYNC));
  localparam logic [9:0]  V_LAST = 10'(VT - 1);
  localparam logic [9:0]  V_DISP = 10'(V_DISPLAY);
  localparam logic [9:0]  VS_BEG = 10'(sync_beg(V_DISPLAY, V_FRONT));
  localparam logic [9:0]  VS_END = 10'(sync_end(V_DISPLAY, V_FRONT, V_SYNC));

  generate
    if (S < 1 || S > 5) begin : g_bad_depth
      $error("vga_scanout: IN_BITS-OUT_BITS must be 1..5");
    end
    if (PIPE < 0 || PIPE > 15) begin : g_bad_pipe
      $error("vga_scanout: PIPE must be 0..15");
    end
  endgenerate

  // Raster counters; frame advances on the edge where both h and v wrap.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      h_count <= '0;
      v_count <= '0;
      frame   <= '0;
    end else if (h_count == H_LAST) begin
      h_count <= '0;
      if (v_count == V_LAST) begin
        v_count <= '0;
        frame   <= frame + 1'b1;
      end else begin
        v_count <= v_count + 1'b1;
      end
    end else begin
      h_count <= h_count + 1'b1;
    end
  end

  assign active       = (h_count < H_DISP) && (v_count < V_DISP);
  assign line_stb     = (h_count == H_DISP);
  assign frame_stb    = (h_count == '0) && (v_count == '0);
  assign prefetch_stb = (h_count == H_PREF);

  tap_t cur, dly;

  always_comb begin
    cur        = '0;
    cur.active = active;
    cur.hs     = (h_count >= HS_BEG) && (h_count < HS_END);
    cur.vs     = (v_count >= VS_BEG) && (v_count < VS_END);
    cur.h3     = h_count[2:0];
    cur.v2     = v_count[1:0];
`ifdef VGA_SCANOUT_TEMPORAL_DITHER_EN
    cur.f0     = frame[0];
`endif
  end

  // Delay line matching renderer latency; a zeroed tap reads as blank with syncs idle.
  generate
    if (PIPE == 0) begin : g_nopipe
      assign dly = cur;
    end else begin : g_pipe
      tap_t tap_q [PIPE];
      always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < PIPE; k++) tap_q[k] <= '0;
        end else begin
          tap_q[0] <= cur;
          for (int k = 1; k < PIPE; k++) tap_q[k] <= tap_q[k-1];
        end
      end
      assign dly = tap_q[PIPE-1];
    end
  endgenerate

  logic [2:0] di;
  logic [4:0] b5;

  always_comb begin
`ifdef VGA_SCANOUT_TEMPORAL_DITHER_EN
    di = dly.h3 ^ {3{dly.f0}};
`else
    di = dly.h3;
`endif
    b5 = bayer5(di, dly.v2);
  end

  logic [2:0][IN_BITS-1:0]  cin;
  logic [2:0][OUT_BITS-1:0] cout;

  assign cin = {r_in, g_in, b_in};

  generate
    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
      vga_dither_ch #(
        .IN_BITS (IN_BITS),
        .OUT_BITS(OUT_BITS)
      ) u_ch (
        .c     (cin[ch]),
        .b5    (b5),
        .active(dly.active),
        .q     (cout[ch])
      );
    end
  endgenerate

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
      g_out <= '0;
      b_out <= '0;
      hsync <= ~HSYNC_POL;
      vsync <= ~VSYNC_POL;
    end else begin
      r_out <= cout[2];
      g_out <= cout[1];
      b_out <= cout[0];
      hsync <= dly.hs ? HSYNC_POL : ~HSYNC_POL;
      vsync <= dly.vs ? VSYNC_POL : ~VSYNC_POL;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout using a shrunken mode so whole frames fit in a short run.
module tb_vga_scanout;
  localparam int HD = 24, HF = 4, HS = 6, HB = 6;
  localparam int VD = 12, VF = 2, VS = 2, VB = 4;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int PIPE = 2, PREF = 4, IB = 6, OB = 2, S = IB - OB;
  localparam int FT = HT * VT;

  logic        clk48 = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] h_count;
  logic [9:0]  v_count;
  logic [10:0] frame;
  logic        active, line_stb, frame_stb, prefetch_stb;
  logic [5:0]  r_in = '0, g_in = '0, b_in = '0;
  logic [1:0]  r_out, g_out, b_out;
  logic        hsync, vsync;

  int errors = 0;
  int checks = 0;

  vga_scanout #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .IN_BITS(IB), .OUT_BITS(OB),
    .PIPE(PIPE), .PREFETCH(PREF), .FRAME_BITS(11)
  ) dut (
    .clk48(clk48), .rst_n(rst_n), .h_count(h_count), .v_count(v_count), .frame(frame),
    .active(active), .line_stb(line_stb), .frame_stb(frame_stb), .prefetch_stb(prefetch_stb),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .hsync(hsync), .vsync(vsync)
  );

  always #5 clk48 = ~clk48;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Reference: pixel value for colour c whose counter state was m cycles after reset release.
  function automatic int exp_col(int c, int m);
    int h, v, i, j, x0, x1, x2, b5, q;
    if (m < 0) return 0;
    h = m % HT;
    v = (m / HT) % VT;
    if (h >= HD || v >= VD) return 0;
    i = h % 8;
    j = v % 4;
`ifdef VGA_SCANOUT_TEMPORAL_DITHER_EN
    if ((m / FT) % 2 == 1) i = 7 - i;
`endif
    x0 = (i % 2) ^ (j % 2);
    x1 = ((i / 2) % 2) ^ ((j / 2) % 2);
    x2 = i / 4;
    b5 = 16 * x0 + 8 * (i % 2) + 4 * x1 + 2 * ((i / 2) % 2) + x2;
    q  = (c + b5 / (1 << (5 - S))) / (1 << S);
    return (q > (1 << OB) - 1) ? (1 << OB) - 1 : q;
  endfunction

  function automatic int exp_hs(int m);
    int h;
    if (m < 0) return 1;
    h = m % HT;
    return (h >= HD + HF && h < HD + HF + HS) ? 0 : 1;
  endfunction

  function automatic int exp_vs(int m);
    int v;
    if (m < 0) return 1;
    v = (m / HT) % VT;
    return (v >= VD + VF && v < VD + VF + VS) ? 0 : 1;
  endfunction

  // Leaves the bench at the negedge where reset releases: cycle 0, counters at (0,0).
  task automatic do_reset();
    @(negedge clk48);
    rst_n = 1'b0;
    r_in = '0; g_in = '0; b_in = '0;
    repeat (2) @(negedge clk48);
    rst_n = 1'b1;
  endtask

  // Wait for counters (th,tv) on a frame of parity fpar (-1: any parity), bounded.
  task automatic seek(input int th, input int tv, input int fpar, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 3 * FT; n++) begin
      @(posedge clk48); #1;
      if (h_count == th && v_count == tv && (fpar < 0 || int'(frame[0]) == fpar)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    int r, g, b, h, v, fpar, er, eg, eb, ehs, evs;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int k_line, k_pref, k_hs, n_hs, k_vs, k_frm, f_frm, n_line;
    int rh[8], gh[8], bh[8];
    int m;

    // Reset state
    #12;
    check("rst_h", h_count, 0);
    check("rst_v", v_count, 0);
    check("rst_frame", frame, 0);
    check("rst_r", r_out, 0);
    check("rst_g", g_out, 0);
    check("rst_b", b_out, 0);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_frame_stb", frame_stb, 1);

    // Frame-level timing after release
    do_reset();
    #1;
    check("first_frame_stb", frame_stb, 1);
    k_line = -1; k_pref = -1; k_hs = -1; n_hs = 0; k_vs = -1; k_frm = -1; f_frm = -1; n_line = 0;
    for (int k = 1; k <= FT + 10; k++) begin
      @(posedge clk48); #1;
      if (line_stb && k_line < 0) k_line = k;
      if (line_stb && k <= FT) n_line++;
      if (prefetch_stb && k_pref < 0) k_pref = k;
      if (!hsync && k < HT) begin
        n_hs++;
        if (k_hs < 0) k_hs = k;
      end
      if (!vsync && k_vs < 0) k_vs = k;
      if (frame_stb && k_frm < 0) begin
        k_frm = k;
        f_frm = int'(frame);
      end
    end
    check("line_stb_at", k_line, HD);
    check("line_stb_count", n_line, VT);
    check("prefetch_at", k_pref, HD - PREF);
    check("hsync_first_low", k_hs, HD + HF + PIPE + 1);
    check("hsync_low_len", n_hs, HS);
    check("vsync_first_low", k_vs, (VD + VF) * HT + PIPE + 1);
    check("next_frame_stb", k_frm, FT);
    check("frame_after_wrap", f_frm, 1);

    // Table of fixed colours at chosen pixels
    tbl.push_back('{24, 63,  0,  0,  0, 0, 1, 3, 0, 1, 1});
    tbl.push_back('{24, 32, 63,  1,  0, 0, 2, 2, 3, 1, 1});
    tbl.push_back('{24, 24, 24,  5,  0, 0, 2, 2, 2, 1, 1});
    tbl.push_back('{24, 24, 24,  0,  1, 0, 2, 2, 2, 1, 1});
    tbl.push_back('{24,  0, 32,  2,  0, 0, 1, 0, 2, 1, 1});
    tbl.push_back('{24, 63,  8,  3,  3, 0, 1, 3, 0, 1, 1});
    tbl.push_back('{40,  8,  8,  7,  2, 0, 3, 1, 1, 1, 1});
    tbl.push_back('{63, 63, 63, 25,  0, 0, 0, 0, 0, 1, 1});
    tbl.push_back('{63, 63, 63, 30,  0, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{63, 63, 63,  0, 14, 0, 0, 0, 0, 1, 0});
    tbl.push_back('{63, 63, 63, 23, 11, 0, 3, 3, 3, 1, 1});
    tbl.push_back('{ 8,  8,  8,  0,  0, 0, 0, 0, 0, 1, 1});
    tbl.push_back('{ 8,  8,  8,  1,  0, 0, 1, 1, 1, 1, 1});
`ifdef VGA_SCANOUT_TEMPORAL_DITHER_EN
    tbl.push_back('{24, 24, 24,  0,  0, 1, 2, 2, 2, 1, 1});
    tbl.push_back('{24, 24, 24,  1,  0, 1, 1, 1, 1, 1, 1});
`else
    tbl.push_back('{24, 24, 24,  0,  0, 1, 1, 1, 1, 1, 1});
    tbl.push_back('{24, 24, 24,  1,  0, 1, 2, 2, 2, 1, 1});
`endif
    for (int n = 0; n < tbl.size(); n++) begin
      r_in = 6'(tbl[n].r); g_in = 6'(tbl[n].g); b_in = 6'(tbl[n].b);
      seek(tbl[n].h, tbl[n].v, tbl[n].fpar, ok);
      if (!ok) begin
        check($sformatf("vec%0d_seek", n), 0, 1);
        continue;
      end
      repeat (PIPE + 1) @(posedge clk48);
      #1;
      check($sformatf("vec%0d_r", n), r_out, tbl[n].er);
      check($sformatf("vec%0d_g", n), g_out, tbl[n].eg);
      check($sformatf("vec%0d_b", n), b_out, tbl[n].eb);
      check($sformatf("vec%0d_hs", n), hsync, tbl[n].ehs);
      check($sformatf("vec%0d_vs", n), vsync, tbl[n].evs);
    end

    // Reset asserted mid-line with live colour on the pins
    r_in = 6'd63; g_in = 6'd63; b_in = 6'd63;
    seek(10, 5, -1, ok);
    check("midrst_seek", ok, 1);
    check("midrst_pre_r", r_out, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_h", h_count, 0);
    check("midrst_v", v_count, 0);
    check("midrst_frame", frame, 0);
    check("midrst_r", r_out, 0);
    check("midrst_hsync", hsync, 1);
    @(negedge clk48);
    rst_n = 1'b1;
    @(posedge clk48); #1;
    check("midrst_restart_h", h_count, 1);
    check("midrst_restart_v", v_count, 0);
    @(posedge clk48); #1;
    check("midrst_flushed_r", r_out, 0);
    @(posedge clk48); #1;
    check("midrst_first_pixel_r", r_out, 3);

    // Randomized colours against the reference model
    do_reset();
    rh[0] = $urandom_range(0, 63); gh[0] = $urandom_range(0, 63); bh[0] = $urandom_range(0, 63);
    r_in = 6'(rh[0]); g_in = 6'(gh[0]); b_in = 6'(bh[0]);
    for (int k = 1; k <= 3 * FT; k++) begin
      @(posedge clk48); #1;
      m = k - 1 - PIPE;
      check("rnd_h", h_count, k % HT);
      check("rnd_v", v_count, (k / HT) % VT);
      check("rnd_frame", frame, k / FT);
      check("rnd_active", active, ((k % HT) < HD && ((k / HT) % VT) < VD) ? 1 : 0);
      check("rnd_line_stb", line_stb, (k % HT == HD) ? 1 : 0);
      check("rnd_frame_stb", frame_stb, (k % FT == 0) ? 1 : 0);
      check("rnd_prefetch", prefetch_stb, (k % HT == HD - PREF) ? 1 : 0);
      check("rnd_r", r_out, exp_col(rh[(k - 1) % 8], m));
      check("rnd_g", g_out, exp_col(gh[(k - 1) % 8], m));
      check("rnd_b", b_out, exp_col(bh[(k - 1) % 8], m));
      check("rnd_hsync", hsync, exp_hs(m));
      check("rnd_vsync", vsync, exp_vs(m));
      rh[k % 8] = $urandom_range(0, 63);
      gh[k % 8] = $urandom_range(0, 63);
      bh[k % 8] = $urandom_range(0, 63);
      r_in = 6'(rh[k % 8]); g_in = 6'(gh[k % 8]); b_in = 6'(bh[k % 8]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
